// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Brief    : Round-robin scheduler feeding one UART transmitter from NREQ
//            byte requesters, with per-packet locking and inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    grant_active
);
    localparam int          c_IDW      = $clog2(NREQ);
    localparam logic [15:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        GAP     = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [c_IDW-1:0] grant_id_q, grant_id_d;
    logic [c_IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [15:0]      gap_cnt_q, gap_cnt_d;

    logic             w_found;
    logic             w_fire;
    logic [c_IDW-1:0] w_sel;
    logic [c_IDW-1:0] w_sel_inc;
    logic [NREQ-1:0]  w_ready;
    logic [7:0]       w_byte;
    logic             w_last;
    state_t           w_post;

    // Arbitration: round-robin in IDLE, owner-only in HOLD; ready is forced
    // low while reset is asserted so no handshake can be seen during it.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_sel   = '0;
        w_ready = '0;
        if (state_q == IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!w_found && req_valid[c_IDW'(idx)]) begin
                    w_found = 1'b1;
                    w_sel   = c_IDW'(idx);
                end
            end
        end else if (state_q == HOLD) begin
            w_found = req_valid[grant_id_q];
            w_sel   = grant_id_q;
        end
        w_fire = w_found & rst_n;
        if (w_fire) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == c_IDW'(i)) begin
                w_byte = req_data[8*i +: 8];
            end
        end
        w_last    = req_last[w_sel];
        w_sel_inc = (int'(w_sel) + 1 >= NREQ) ? '0 : w_sel + 1'b1;
        w_post    = lock_q ? HOLD : IDLE;
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE, HOLD: begin
                if (w_fire) begin
                    tx_data_d  = w_byte;
                    grant_id_d = w_sel;
                    lock_d     = ~w_last;
                    if (w_last) begin
                        rr_ptr_d = w_sel_inc;
                    end
                    state_d = START;
                end
            end
            START: state_d = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = w_post;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = c_GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = w_post;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            gap_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign req_ready    = w_ready;
    assign tx_start     = (state_q == START);
    assign tx_data      = tx_data_q;
    assign grant_id     = grant_id_q;
    assign grant_active = (state_q != IDLE) | lock_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Brief    : Scoreboard bench for uart_tx_sched with a UART busy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;
    localparam int NREQ = 4;
    localparam int GAP  = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        grant_active;

    int checks   = 0;
    int failures = 0;
    int starts   = 0;
    bit busy_en  = 1'b1;

    // Expected transfers as {grant_id, byte}, in send order.
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .grant_active(grant_active)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: busy rises one clock after tx_start, stays 10 clocks.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (busy_en && tx_start === 1'b1) begin
                @(posedge clk);
                #2;
                tx_busy = 1'b1;
                repeat (10) @(posedge clk);
                #2;
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start === 1'b1) begin
                starts++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got id/data=%0d/%02h, required no transfer", grant_id, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant_id, tx_data} !== e) begin
                        failures++;
                        $display("FAIL sb_xfer: got id/data=%0d/%02h, required %0d/%02h",
                                 grant_id, tx_data, e[9:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic wait_for(input int kind, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            case (kind)
                0:       ok = (req_ready != 4'b0000);
                1:       ok = (grant_active == 1'b0);
                2:       ok = (tx_busy == 1'b1);
                default: ok = (tx_busy == 1'b0);
            endcase
            if (ok) break;
            tick();
        end
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'h44332211;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start: got %b, required 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %02h, required 00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
        checks++; if (grant_active !== 1'b0) begin failures++; $display("FAIL rst_grant_active: got %b, required 0", grant_active); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
        req_valid = 4'b0000;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_rr_pair();
        bit ok;
        req_last  = 4'b1111;
        req_data  = 32'hC3B2A100;
        req_valid = 4'b0110;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rr_first_ready: got %b, required 0010", req_ready); end
        exp_q.push_back({2'd1, 8'hA1});
        tick();
        req_valid = 4'b0100;
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL rr_tx_start_latency: got %b, required 1", tx_start); end
        checks++; if (tx_data !== 8'hA1) begin failures++; $display("FAIL rr_tx_data: got %02h, required a1", tx_data); end
        checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL rr_grant_id: got %0d, required 1", grant_id); end
        #1;
        wait_for(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rr_second_timeout: got no ready, required ready"); end
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rr_second_ready: got %b, required 0100", req_ready); end
        exp_q.push_back({2'd2, 8'hB2});
        tick();
        req_valid = 4'b0000;
        #1;
        wait_for(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rr_idle_timeout: got active, required idle"); end
        // rr_ptr must now be 3: requester 3 beats requester 0.
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rr_ptr3_ready: got %b, required 1000", req_ready); end
        exp_q.push_back({2'd3, 8'hC3});
        tick();
        req_valid = 4'b0000;
        #1;
        wait_for(1, ok);
    endtask

    task automatic test_packet_lock();
        bit ok;
        int viol;
        req_data  = 32'hD3000041;
        req_last  = 4'b1110;
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL lock_first_ready: got %b, required 0001", req_ready); end
        exp_q.push_back({2'd0, 8'h41});
        tick();
        req_valid = 4'b1000;
        viol = 0;
        repeat (40) begin
            tick();
            if (req_ready !== 4'b0000) viol++;
        end
        checks++; if (viol != 0) begin failures++; $display("FAIL lock_hold_ready3: got %0d cycles with ready, required 0", viol); end
        checks++; if (grant_active !== 1'b1) begin failures++; $display("FAIL lock_hold_active: got %b, required 1", grant_active); end
        req_data  = 32'hD3000042;
        req_last  = 4'b1111;
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL lock_second_ready: got %b, required 0001", req_ready); end
        exp_q.push_back({2'd0, 8'h42});
        tick();
        req_valid = 4'b1000;
        #1;
        wait_for(0, ok);
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL lock_release_ready: got %b, required 1000", req_ready); end
        exp_q.push_back({2'd3, 8'hD3});
        tick();
        req_valid = 4'b0000;
        #1;
        wait_for(1, ok);
    endtask

    task automatic test_gap();
        bit ok;
        int n;
        req_data  = 32'h00E2E100;
        req_last  = 4'b1111;
        req_valid = 4'b0100;
        #1;
        wait_for(0, ok);
        exp_q.push_back({2'd2, 8'hE2});
        tick();
        req_valid = 4'b0010;
        #1;
        wait_for(2, ok);
        wait_for(3, ok);
        n = 0;
        while (req_ready == 4'b0000 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n != GAP) begin failures++; $display("FAIL gap_length: got %0d clocks, required %0d", n, GAP); end
        exp_q.push_back({2'd1, 8'hE1});
        tick();
        req_valid = 4'b0000;
        #1;
        wait_for(1, ok);
    endtask

    task automatic test_busy_stuck();
        int bad_rdy;
        int bad_act;
        busy_en   = 1'b0;
        req_data  = 32'h000000F0;
        req_last  = 4'b1111;
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL stuck_ready: got %b, required 0001", req_ready); end
        exp_q.push_back({2'd0, 8'hF0});
        tick();
        req_valid = 4'b1111;
        bad_rdy = 0;
        bad_act = 0;
        repeat (50) begin
            tick();
            if (req_ready !== 4'b0000) bad_rdy++;
            if (grant_active !== 1'b1) bad_act++;
        end
        checks++; if (bad_rdy != 0) begin failures++; $display("FAIL stuck_no_ready: got %0d cycles with ready, required 0", bad_rdy); end
        checks++; if (bad_act != 0) begin failures++; $display("FAIL stuck_active: got %0d inactive cycles, required 0", bad_act); end
        req_valid = 4'b0000;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n   = 1'b1;
        busy_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        req_data  = 32'h335A2211;
        req_last  = 4'b1011;
        req_valid = 4'b0100;
        #1;
        wait_for(0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_ready_timeout: got no ready, required ready"); end
        exp_q.push_back({2'd2, 8'h5A});
        tick();
        req_valid = 4'b0000;
        #1;
        wait_for(2, ok);
        repeat (2) tick();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL mid_tx_start: got %b, required 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_tx_data: got %02h, required 00", tx_data); end
        checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL mid_grant_id: got %0d, required 0", grant_id); end
        checks++; if (grant_active !== 1'b0) begin failures++; $display("FAIL mid_grant_active: got %b, required 0", grant_active); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_req_ready: got %b, required 0000", req_ready); end
        repeat (12) tick();
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_post_ready: got %b, required 0001", req_ready); end
        exp_q.push_back({2'd0, 8'h11});
        tick();
        req_valid = 4'b0000;
        #1;
        wait_for(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL mid_idle_timeout: got active, required idle"); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int s0;
        int n;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n    = 1'b1;
        req_data = 32'h33323130;
        req_last = 4'b1111;
        for (int r = 0; r < 8; r++) begin
            exp_q.push_back({2'(r % 4), 8'(8'h30 + (r % 4))});
        end
        s0 = starts;
        req_valid = 4'b1111;
        n = 0;
        while (starts - s0 < 8 && n < 1000) begin
            tick();
            n++;
        end
        req_valid = 4'b0000;
        #1;
        wait_for(1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rr8_idle_timeout: got active, required idle"); end
        checks++; if (starts - s0 != 8) begin failures++; $display("FAIL rr8_start_count: got %0d, required 8", starts - s0); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr8_pending: got %0d unsent, required 0", exp_q.size()); end
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        req_last  = 4'b0000;
        test_reset();
        test_rr_pair();
        test_packet_lock();
        test_gap();
        test_busy_stuck();
        test_reset_mid();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one UART transmitter (2..8).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 0, giving the idle clocks inserted after each frame completes (0..65535).
REQ-003 The block SHALL have port clk, input, 1, the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid, input, NREQ, where bit i means requester i offers a byte.
REQ-006 The block SHALL have port req_data, input, 8*NREQ, where requester i's byte is bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, NREQ, where bit i marks the offered byte as the final byte of requester i's packet.
REQ-008 The block SHALL have port req_ready, output, NREQ, where bit i means the scheduler accepts requester i's byte this cycle.
REQ-009 The block SHALL have port tx_start, output, 1, a one-cycle pulse telling the UART transmitter to send tx_data.
REQ-010 The block SHALL have port tx_data, output, 8, the byte for the transmitter, held stable until the next accepted transfer.
REQ-011 The block SHALL have port tx_busy, input, 1, driven high by the transmitter while it shifts a frame.
REQ-012 The block SHALL have port grant_id, output, clog2(NREQ), giving the index of the current or most recent owner.
REQ-013 The block SHALL have port grant_active, output, 1, high while a packet is in progress or a frame is in flight.

Function
REQ-014 The block SHALL implement FSM states IDLE, START, WAIT_HI, WAIT_LO, GAP and HOLD.
REQ-015 req_ready SHALL be nonzero only in IDLE or HOLD, at most one bit high, and combinational from the state and req_valid.
REQ-016 In IDLE, the block SHALL set req_ready for the first requester with req_valid high, searching upward from rr_ptr and wrapping modulo NREQ.
REQ-017 In HOLD, only the locked owner SHALL be eligible; other req_valid bits SHALL be ignored, and the block SHALL remain in HOLD with no timeout until the owner asserts valid.
REQ-018 A transfer SHALL occur on a clock edge with req_valid[i] and req_ready[i] both high; at that edge the block SHALL load tx_data with the byte, set tx_start to 1, set grant_id to i, and enter START.
REQ-019 tx_start SHALL be high for exactly the one START cycle, giving a latency of 1 clock from the transfer edge to tx_start high.
REQ-020 START SHALL go to WAIT_HI unconditionally.
REQ-021 WAIT_HI SHALL go to WAIT_LO when tx_busy is 1.
REQ-022 WAIT_LO SHALL go to GAP when tx_busy is 0, or directly to the post-gap decision if GAP_CYCLES is 0.
REQ-023 GAP SHALL count GAP_CYCLES clocks and then make the post-gap decision.
REQ-024 The post-gap decision SHALL go to HOLD if the lock is set and to IDLE otherwise.
REQ-025 The lock SHALL be set on a transfer with req_last[i]=0 and cleared on a transfer with req_last[i]=1; a single-byte packet (last=1) SHALL never lock.
REQ-026 rr_ptr SHALL update to (i+1) mod NREQ only on a transfer with last=1, so that intermediate bytes do not advance fairness.
REQ-027 grant_active SHALL equal (state != IDLE) OR lock.
REQ-028 No new transfer SHALL be accepted before the previous frame's tx_busy falls and the gap expires, so there is never more than one byte outstanding.
REQ-029 If tx_busy is already 1 when the block enters WAIT_HI, it SHALL proceed to WAIT_LO on the next clock.
REQ-030 The block SHALL not drop or reorder any byte it has accepted.

Reset
REQ-031 When rst_n=0, the block SHALL immediately set state=IDLE, tx_start=0, tx_data=8'h00, grant_id=0, grant_active=0, req_ready=0, lock=0, rr_ptr=0 and the gap counter to 0, regardless of state.
REQ-032 A reset asserted mid-frame or mid-packet SHALL abandon the packet without resuming it; the first post-reset arbitration SHALL favour requester 0.
REQ-033 After rst_n deasserts, the block SHALL require no initialisation cycles, and IDLE arbitration SHALL be valid on the first clock.

Verification
REQ-034 With reset released and req_valid=4'b0110 and both last=1, the bench SHALL see requester 1 granted with tx_data equal to its byte and tx_start one cycle later; after busy falls, requester 2 SHALL be granted, then rr_ptr SHALL equal 3.
REQ-035 With requester 0 sending 8'h41 (last=0) and then 8'h42 (last=1) while requester 3 is continuously valid, the bench SHALL see 41 and 42 sent back-to-back before any grant to requester 3, and req_ready[3]=0 throughout HOLD.
REQ-036 With GAP_CYCLES=5 and a busy model that goes high 1 clock after tx_start for 10 clocks, the bench SHALL see exactly 5 clocks between tx_busy falling and the next req_ready.
REQ-037 With tx_busy held 0 after tx_start, the bench SHALL see the block remain in WAIT_HI with req_ready=0 and grant_active=1 indefinitely.
REQ-038 With rst_n pulsed low during WAIT_LO of a locked packet, the bench SHALL see all outputs zero asynchronously and, after release, requester 0 win a fresh arbitration.
REQ-039 With all four requesters continuously valid and last=1 for 8 frames, the bench SHALL see a grant order of 0,1,2,3,0,1,2,3 and a tx_start count of 8.
